// File: rtl/eth_rx_length_framer.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_length_framer
// Description : Pairs each length-FIFO entry with its RX frame and emits a
//               length-prefixed byte stream (2-byte big-endian header, then
//               payload). Short/long frames are flagged and truncated or
//               drained; oversize frames are dropped whole.
//               Optional statistics counters: ETH_RX_LENGTH_FRAMER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_length_framer #(
  parameter int LENGTH_WIDTH     = 11,
  parameter int MAX_FRAME_LENGTH = 1522,
  parameter int HEADER_ENABLE    = 1
) (
  input  logic                    logic_clk,
  input  logic                    logic_rst_n,
  input  logic [LENGTH_WIDTH-1:0] s_len_tdata,
  input  logic                    s_len_tvalid,
  output logic                    s_len_tready,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    status_frame_done,
  output logic                    status_len_mismatch,
  output logic                    status_oversize
`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
  ,
  output logic [15:0]             stat_frame_count,
  output logic [15:0]             stat_error_count,
  output logic [15:0]             stat_drop_count
`endif
);

  localparam logic [11:0] c_max_len = 12'(MAX_FRAME_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_HI  = 3'd1,
    S_HDR_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DRAIN   = 3'd4,
    S_DROP    = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_len, w_len_nxt;
  logic [11:0] r_count, w_count_nxt;
  logic        r_active;
  logic        w_load;
  logic [11:0] w_len_in;
  logic [11:0] w_count_inc;
  logic        w_len_rdy, w_data_rdy;
  logic        w_out_vld, w_out_last, w_out_user;
  logic [7:0]  w_out_data;
  logic        w_done, w_mismatch, w_oversize;

  // The output register may take a new beat when empty or being drained.
  assign w_load      = !m_axis_tvalid || m_axis_tready;
  // Length words carry count-1; 12 bits keep an all-ones word from wrapping.
  assign w_len_in    = 12'(s_len_tdata) + 12'd1;
  assign w_count_inc = r_count + 12'd1;

  assign s_len_tready  = w_len_rdy;
  assign s_axis_tready = w_data_rdy;

  // Holds the length port off until the cycle after reset is released.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) r_active <= 1'b0;
    else              r_active <= 1'b1;
  end

  // State, held length and byte counter registers.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 12'd0;
      r_count <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state, input-ready and output-beat selection.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_len_rdy   = 1'b0;
    w_data_rdy  = 1'b0;
    w_out_vld   = 1'b0;
    w_out_data  = 8'd0;
    w_out_last  = 1'b0;
    w_out_user  = 1'b0;
    w_done      = 1'b0;
    w_mismatch  = 1'b0;
    w_oversize  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_len_rdy = r_active;
        if (s_len_tvalid && r_active) begin
          if (w_len_in > c_max_len) begin
            w_oversize  = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            w_len_nxt   = w_len_in;
            w_count_nxt = 12'd0;
            if (HEADER_ENABLE != 0) begin
              // Load the high header byte straight away when the output is
              // free, giving one cycle from length handshake to valid.
              if (w_load) begin
                w_out_vld   = 1'b1;
                w_out_data  = {4'd0, w_len_in[11:8]};
                w_state_nxt = S_HDR_LO;
              end else begin
                w_state_nxt = S_HDR_HI;
              end
            end else begin
              w_state_nxt = S_PAYLOAD;
            end
          end
        end
      end
      S_HDR_HI: begin
        if (w_load) begin
          w_out_vld   = 1'b1;
          w_out_data  = {4'd0, r_len[11:8]};
          w_state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (w_load) begin
          w_out_vld   = 1'b1;
          w_out_data  = r_len[7:0];
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_data_rdy = w_load;
        if (s_axis_tvalid && w_load) begin
          w_count_nxt = w_count_inc;
          w_out_vld   = 1'b1;
          w_out_data  = s_axis_tdata;
          if (s_axis_tlast) begin
            w_out_last  = 1'b1;
            w_state_nxt = S_IDLE;
            if (w_count_inc == r_len) begin
              w_out_user = s_axis_tuser;
              w_done     = !s_axis_tuser;
            end else begin
              w_out_user = 1'b1;
              w_mismatch = 1'b1;
            end
          end else if (w_count_inc == r_len) begin
            // Frame longer than advertised: close it here, discard the rest.
            w_out_last  = 1'b1;
            w_out_user  = 1'b1;
            w_mismatch  = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN, S_DROP: begin
        w_data_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single registered output stage; holds while stalled.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (w_load) begin
      m_axis_tvalid <= w_out_vld;
      m_axis_tdata  <= w_out_data;
      m_axis_tlast  <= w_out_last;
      m_axis_tuser  <= w_out_user;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      status_frame_done   <= 1'b0;
      status_len_mismatch <= 1'b0;
      status_oversize     <= 1'b0;
    end else begin
      status_frame_done   <= w_done;
      status_len_mismatch <= w_mismatch;
      status_oversize     <= w_oversize;
    end
  end

`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
  // Saturating event counters driven by the status pulses.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      stat_frame_count <= 16'd0;
      stat_error_count <= 16'd0;
      stat_drop_count  <= 16'd0;
    end else begin
      if (status_frame_done && (stat_frame_count != 16'hFFFF))
        stat_frame_count <= stat_frame_count + 16'd1;
      if (status_len_mismatch && (stat_error_count != 16'hFFFF))
        stat_error_count <= stat_error_count + 16'd1;
      if (status_oversize && (stat_drop_count != 16'hFFFF))
        stat_drop_count <= stat_drop_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_length_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_length_framer
// Description : Directed self-checking bench for eth_rx_length_framer.
//               Build with ETH_RX_LENGTH_FRAMER_STATS_EN to cover counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_length_framer;

  logic        logic_clk = 1'b0;
  logic        logic_rst_n;
  logic [10:0] s_len_tdata;
  logic        s_len_tvalid;
  logic        s_len_tready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        status_frame_done;
  logic        status_len_mismatch;
  logic        status_oversize;
`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
  logic [15:0] stat_frame_count;
  logic [15:0] stat_error_count;
  logic [15:0] stat_drop_count;
`endif

  eth_rx_length_framer dut (
    .logic_clk          (logic_clk),
    .logic_rst_n        (logic_rst_n),
    .s_len_tdata        (s_len_tdata),
    .s_len_tvalid       (s_len_tvalid),
    .s_len_tready       (s_len_tready),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .status_frame_done  (status_frame_done),
    .status_len_mismatch(status_len_mismatch),
    .status_oversize    (status_oversize)
`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
    ,
    .stat_frame_count   (stat_frame_count),
    .stat_error_count   (stat_error_count),
    .stat_drop_count    (stat_drop_count)
`endif
  );

  always #5 logic_clk = ~logic_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Downstream ready: steady high, or alternating 1-on/1-off.
  bit toggle_mode = 1'b0;
  always @(posedge logic_clk) begin
    #1;
    m_axis_tready = toggle_mode ? ~m_axis_tready : 1'b1;
  end

  // Output monitor: beats {last,user,data}, pulse counts, stall stability.
  logic [9:0] cap_q[$];
  int   cnt_done = 0, cnt_mis = 0, cnt_ovs = 0, hold_viol = 0;
  bit   prev_stall = 1'b0;
  logic [9:0] prev_beat;
  always @(negedge logic_clk) begin
    if (!logic_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_axis_tvalid && ({m_axis_tlast, m_axis_tuser, m_axis_tdata} == prev_beat)))
        hold_viol++;
      if (m_axis_tvalid && m_axis_tready)
        cap_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      cnt_done += int'(status_frame_done);
      cnt_mis  += int'(status_len_mismatch);
      cnt_ovs  += int'(status_oversize);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_m_tuser"}, m_axis_tuser, 0);
    check({tag, "_s_len_tready"}, s_len_tready, 0);
    check({tag, "_s_axis_tready"}, s_axis_tready, 0);
    check({tag, "_status"}, {status_frame_done, status_len_mismatch, status_oversize}, 0);
  endtask

  // Expected stream for the current section.
  logic [9:0] exp_q[$];
  int base_idx, d0, m0, o0, h0, e_done, e_mis, e_ovs;

  task automatic begin_section();
    base_idx = cap_q.size();
    exp_q.delete();
    d0 = cnt_done; m0 = cnt_mis; o0 = cnt_ovs; h0 = hold_viol;
    e_done = 0; e_mis = 0; e_ovs = 0;
  endtask

  task automatic expect_frame(input int len_word, input int nbytes, input int seed, input logic ulast);
    int L, nout;
    logic last, user;
    L = len_word + 1;
    if (L > 1522) begin
      e_ovs++;
    end else begin
      exp_q.push_back({2'b00, 8'(L >> 8)});
      exp_q.push_back({2'b00, 8'(L)});
      nout = (nbytes < L) ? nbytes : L;
      for (int i = 0; i < nout; i++) begin
        last = (i == nout - 1);
        user = last ? ((nbytes == L) ? ulast : 1'b1) : 1'b0;
        exp_q.push_back({last, user, 8'(seed + i)});
      end
      if (nbytes == L) begin
        if (!ulast) e_done++;
      end else begin
        e_mis++;
      end
    end
  endtask

  task automatic end_section(input string tag);
    int n;
    repeat (10) @(posedge logic_clk);
    #1;
    n = cap_q.size() - base_idx;
    check({tag, "_beat_count"}, n, exp_q.size());
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), cap_q[base_idx + i], exp_q[i]);
    check({tag, "_frame_done_pulses"}, cnt_done - d0, e_done);
    check({tag, "_mismatch_pulses"}, cnt_mis - m0, e_mis);
    check({tag, "_oversize_pulses"}, cnt_ovs - o0, e_ovs);
    check({tag, "_stall_hold"}, hold_viol - h0, 0);
  endtask

  task automatic send_frame(input int len_word, input int nbytes, input int seed, input logic ulast,
                            input bit chk_lat, input bit chk_rdy, input int stop_after);
    bit ok;
    s_len_tdata   = 11'(len_word);
    s_len_tvalid  = 1'b1;
    // Byte 0 is presented early to confirm it is not taken in IDLE.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'(seed);
    s_axis_tlast  = (nbytes == 1);
    s_axis_tuser  = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge logic_clk);
      if (s_len_tready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("len_handshake_timeout", 0, 1);
      s_len_tvalid = 1'b0; s_axis_tvalid = 1'b0;
      return;
    end
    check("no_lookahead", s_axis_tready, 0);
    @(posedge logic_clk); #1;
    s_len_tvalid = 1'b0;
    if (chk_lat) begin
      @(negedge logic_clk);
      check("hdr_latency_valid", m_axis_tvalid, 1);
      check("hdr_latency_data", m_axis_tdata, 8'((len_word + 1) >> 8));
    end
    for (int i = 0; i < nbytes; i++) begin
      if (stop_after > 0 && i == stop_after) break;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(seed + i);
      s_axis_tlast  = (i == nbytes - 1);
      s_axis_tuser  = (i == nbytes - 1) ? ulast : 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge logic_clk);
        if (chk_rdy && t == 0) check("drop_tready_high", s_axis_tready, 1);
        if (s_axis_tready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check("byte_handshake_timeout", 0, 1);
        break;
      end
      @(posedge logic_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  initial begin
    logic_rst_n   = 1'b0;
    s_len_tdata   = '0;
    s_len_tvalid  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge logic_clk);
    #1;
    chk_zero("reset");
    @(negedge logic_clk);
    logic_rst_n = 1'b1;
    @(posedge logic_clk); #1;

    // 64-byte frame, good.
    begin_section();
    expect_frame(63, 64, 8'h00, 1'b0);
    send_frame(63, 64, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    end_section("len64");

    // Short frame followed by a normal one.
    begin_section();
    expect_frame(99, 60, 8'h10, 1'b0);
    send_frame(99, 60, 8'h10, 1'b0, 1'b0, 1'b0, 0);
    expect_frame(3, 4, 8'h80, 1'b0);
    send_frame(3, 4, 8'h80, 1'b0, 1'b0, 1'b0, 0);
    end_section("short");

    // Long frame, drained, then next frame.
    begin_section();
    expect_frame(9, 20, 8'h20, 1'b0);
    send_frame(9, 20, 8'h20, 1'b0, 1'b0, 1'b0, 0);
    expect_frame(1, 2, 8'h40, 1'b0);
    send_frame(1, 2, 8'h40, 1'b0, 1'b0, 1'b0, 0);
    end_section("long");

    // Oversize frame dropped whole.
    begin_section();
    expect_frame(1599, 1600, 8'h00, 1'b0);
    send_frame(1599, 1600, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    end_section("oversize");

    // Exactly the maximum length, then an all-ones length word.
    begin_section();
    expect_frame(1521, 1522, 8'h03, 1'b0);
    send_frame(1521, 1522, 8'h03, 1'b0, 1'b0, 1'b0, 0);
    expect_frame(2047, 2048, 8'h00, 1'b0);
    send_frame(2047, 2048, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    end_section("boundary");

    // Back-to-back frames with alternating downstream ready.
    toggle_mode = 1'b1;
    begin_section();
    expect_frame(63, 64, 8'h00, 1'b0);
    send_frame(63, 64, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    expect_frame(63, 64, 8'h55, 1'b0);
    send_frame(63, 64, 8'h55, 1'b0, 1'b0, 1'b0, 0);
    expect_frame(63, 64, 8'hAA, 1'b0);
    send_frame(63, 64, 8'hAA, 1'b0, 1'b0, 1'b0, 0);
    end_section("b2b_toggle");
    toggle_mode = 1'b0;
    repeat (3) @(posedge logic_clk);
    #1;

    // Correct length but upstream marked the frame bad.
    begin_section();
    expect_frame(3, 4, 8'h33, 1'b1);
    send_frame(3, 4, 8'h33, 1'b1, 1'b0, 1'b0, 0);
    end_section("tuser_bad");

    // Reset in the middle of a payload, then a fresh frame.
    send_frame(63, 64, 8'h00, 1'b0, 1'b0, 1'b0, 20);
    #1;
    logic_rst_n = 1'b0;
    #1;
    chk_zero("midreset");
`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
    check("stat_frame_reset", stat_frame_count, 0);
    check("stat_error_reset", stat_error_count, 0);
    check("stat_drop_reset", stat_drop_count, 0);
`endif
    repeat (2) @(posedge logic_clk);
    @(negedge logic_clk);
    logic_rst_n = 1'b1;
    @(posedge logic_clk); #1;
    begin_section();
    expect_frame(63, 64, 8'h77, 1'b0);
    send_frame(63, 64, 8'h77, 1'b0, 1'b0, 1'b0, 0);
    end_section("after_reset");
`ifdef ETH_RX_LENGTH_FRAMER_STATS_EN
    check("stat_frame_one", stat_frame_count, 1);
    check("stat_error_zero", stat_error_count, 0);
    check("stat_drop_zero", stat_drop_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_length_framer.md
Name: eth_rx_length_framer

Overview:
- Sits directly downstream of the 1G GMII MAC RX FIFO and its companion packet-length FIFO, in the logic clock domain.
- Pairs each entry from the length stream with the matching frame on the RX data stream.
- Emits a length-prefixed byte stream: 2-byte big-endian header, then the payload.
- Checks the byte count against the advertised length; flags and truncates or drains on mismatch; drops oversize frames.

Parameters:
- LENGTH_WIDTH, 11, width of the incoming length word.
- MAX_FRAME_LENGTH, 1522, largest accepted frame in bytes; larger frames are dropped.
- HEADER_ENABLE, 1, 1 = emit 2-byte length header before the payload; 0 = payload only, with checking still active.

Ports:
- logic_clk  in  1  clock.
- logic_rst_n  in  1  asynchronous active-low reset.
- s_len_tdata  in  LENGTH_WIDTH  frame byte count minus one.
- s_len_tvalid  in  1  length word valid.
- s_len_tready  out  1  length word accepted.
- s_axis_tdata  in  8  RX frame byte.
- s_axis_tvalid  in  1  RX byte valid.
- s_axis_tready  out  1  RX byte accepted.
- s_axis_tlast  in  1  last RX byte of frame.
- s_axis_tuser  in  1  RX bad-frame flag on last byte.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last output byte of frame.
- m_axis_tuser  out  1  output frame bad; valid with tlast.
- status_frame_done  out  1  1-cycle pulse per frame completed without error.
- status_len_mismatch  out  1  1-cycle pulse per length/data mismatch.
- status_oversize  out  1  1-cycle pulse per dropped oversize frame.

Behaviour:
- Clock and reset: one clock, logic_clk. Reset logic_rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, byte counter 0, held length 0.
- Output stage: single registered stage. The output register loads when !m_axis_tvalid || m_axis_tready. m_axis_* hold stable while tvalid && !tready.
- Length definition: L = s_len_tdata + 1 bytes. Held length and byte counter are 12 bits, so an all-ones length word does not wrap.
- IDLE:
  - s_len_tready = 1 and s_axis_tready = 0.
  - On a length handshake: if L > MAX_FRAME_LENGTH, go to DROP and pulse status_oversize. Otherwise latch L, clear the counter, and go to HDR_HI (HEADER_ENABLE=1) or PAYLOAD (HEADER_ENABLE=0).
- HDR_HI, HDR_LO:
  - Each loads one output byte: L[15:8], then L[7:0], with 12-bit L zero-extended to 16 bits.
  - tlast = 0. Neither input is accepted. Advance when the output register loads.
- PAYLOAD:
  - s_axis_tready = output register can load. Each accepted byte is forwarded and the counter increments.
  - Let n = counter value after the increment.
  - tlast && n == L: out tlast=1, tuser=s_axis_tuser. Pulse status_frame_done if tuser=0. Go to IDLE.
  - tlast && n < L (short frame): out tlast=1, tuser=1. Pulse status_len_mismatch. Go to IDLE.
  - !tlast && n == L (long frame): out tlast=1, tuser=1. Pulse status_len_mismatch. Go to DRAIN.
- DRAIN: s_axis_tready = 1, bytes are discarded, and no output is produced. On an accepted tlast, go to IDLE.
- DROP: same as DRAIN; the frame is fully discarded with no header and no output.
- No lookahead: a data byte is never accepted in IDLE, even if s_axis_tvalid is high before the length word arrives.
- Back-to-back frames: a length word for frame N+1 is accepted in the cycle after frame N's tlast byte enters the output register. There are no idle output cycles beyond the header.
- Latency: accepted input byte to m_axis_tvalid is 1 cycle. Length handshake to first header byte valid is 1 cycle.
- Reset mid-frame: the FSM is immediately in IDLE. Output valid drops asynchronously. The partial frame is not completed.

Optional Feature:
- Macro: ETH_RX_LENGTH_FRAMER_STATS_EN.
- Defined: adds output ports stat_frame_count[15:0], stat_error_count[15:0] and stat_drop_count[15:0]. These increment on status_frame_done, status_len_mismatch and status_oversize respectively. Each saturates at 16'hFFFF and resets to 0.
- Undefined: those ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Length 63 (L=64), 64 data bytes with tlast on byte 64, tuser=0 -> output 0x00, 0x40, then 64 bytes, tlast on the last; status_frame_done pulses once.
- Length 99 (L=100), frame of 60 bytes -> 62 output bytes, tlast=1 and tuser=1 on byte 60; status_len_mismatch pulses; next frame is processed normally.
- Length 9 (L=10), frame of 20 bytes -> output of 0x00, 0x0A, then 10 bytes, tlast=1 and tuser=1 on the 10th; remaining 10 bytes drained; next frame's header appears after the drain.
- Length 1599 (L=1600), 1600-byte frame -> zero output beats; status_oversize pulses; s_axis_tready stays 1 until tlast.
- Three back-to-back 64-byte frames with m_axis_tready toggling in a 1-on/1-off pattern -> data intact and in order, no duplicated or lost bytes, tdata held during stalls.
- logic_rst_n asserted mid-payload, then a fresh 64-byte frame -> all outputs 0 during reset; clean 66-byte output afterwards; stats counters at 0, then 1 frame, when ETH_RX_LENGTH_FRAMER_STATS_EN is defined.
